// File: rtl/regs_wr_arbiter.sv
// Two-requester round-robin write arbiter in front of the register file.
// Grants are combinational. The chosen write is registered toward the
// register file one cycle later. Writes to address 0 are consumed but
// never issued, because register 0 is hard-wired.
module regs_wr_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Hold,
  input  logic          Req0,
  input  logic [AW-1:0] Addr0,
  input  logic [DW-1:0] Data0,
  output logic          Ack0,
  input  logic          Req1,
  input  logic [AW-1:0] Addr1,
  input  logic [DW-1:0] Data1,
  output logic          Ack1,
  output logic          Write_Reg,
  output logic [AW-1:0] W_Addr,
  output logic [DW-1:0] W_Data,
  output logic [15:0]   Wr_Cnt
);

  // Index of the most recently granted requester. It comes out of reset as 1,
  // so requester 0 wins the first contention.
  logic last;

  // Grant selection: reset or Hold blocks both grants; contention goes to the
  // requester that was not granted last.
  always_comb begin
    Ack0 = 1'b0;
    Ack1 = 1'b0;
    if (!Reset && !Hold) begin
      if (Req0 && Req1) begin
        Ack0 = last;
        Ack1 = ~last;
      end else begin
        Ack0 = Req0;
        Ack1 = Req1;
      end
    end
  end

  // Register the granted write, update the priority pointer and count issued writes.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Write_Reg <= 1'b0;
      W_Addr    <= '0;
      W_Data    <= '0;
      Wr_Cnt    <= 16'd0;
      last      <= 1'b1;
    end else if (Ack0) begin
      W_Addr    <= Addr0;
      W_Data    <= Data0;
      last      <= 1'b0;
      Write_Reg <= (Addr0 != '0);
      if (Addr0 != '0) Wr_Cnt <= Wr_Cnt + 16'd1;
    end else if (Ack1) begin
      W_Addr    <= Addr1;
      W_Data    <= Data1;
      last      <= 1'b1;
      Write_Reg <= (Addr1 != '0);
      if (Addr1 != '0) Wr_Cnt <= Wr_Cnt + 16'd1;
    end else begin
      Write_Reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regs_wr_arbiter.sv
// Self-checking bench for regs_wr_arbiter. It combines directed scenarios with
// random traffic, and checks the DUT against a rule-level reference model.
module tb_regs_wr_arbiter;

  logic        Clk;
  logic        Reset;
  logic        Hold;
  logic        Req0, Req1;
  logic [4:0]  Addr0, Addr1;
  logic [31:0] Data0, Data1;
  logic        Ack0, Ack1;
  logic        Write_Reg;
  logic [4:0]  W_Addr;
  logic [31:0] W_Data;
  logic [15:0] Wr_Cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state: who was granted last, and what the register-file port should show.
  int          m_last;
  logic        m_wr;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_cnt;

  regs_wr_arbiter #(.AW(5), .DW(32)) dut (
    .Clk(Clk), .Reset(Reset), .Hold(Hold),
    .Req0(Req0), .Addr0(Addr0), .Data0(Data0), .Ack0(Ack0),
    .Req1(Req1), .Addr1(Addr1), .Data1(Data1), .Ack1(Ack1),
    .Write_Reg(Write_Reg), .W_Addr(W_Addr), .W_Data(W_Data), .Wr_Cnt(Wr_Cnt)
  );

  // Free-running 10-unit clock.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Return the requester that should be granted (0 or 1), or -1 when there is no grant.
  function automatic int expGrant();
    if (Reset || Hold) return -1;
    if (Req0 && Req1) return (m_last == 0) ? 1 : 0;
    if (Req0) return 0;
    if (Req1) return 1;
    return -1;
  endfunction

  task automatic modelReset();
    m_last = 1;
    m_wr   = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_cnt  = 0;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic hold, input logic r0, input logic [4:0] a0,
                               input logic [31:0] d0, input logic r1, input logic [4:0] a1,
                               input logic [31:0] d1);
    Hold = hold; Req0 = r0; Addr0 = a0; Data0 = d0;
    Req1 = r1; Addr1 = a1; Data1 = d1;
  endtask

  // Let the combinational grant settle, then compare every output against the model.
  task automatic checkOutput(input string tag);
    int g;
    #1;
    g = expGrant();
    checkVal({tag, ".ack0"}, 32'(Ack0), 32'(g == 0));
    checkVal({tag, ".ack1"}, 32'(Ack1), 32'(g == 1));
    checkVal({tag, ".write_reg"}, 32'(Write_Reg), 32'(m_wr));
    checkVal({tag, ".w_addr"}, 32'(W_Addr), 32'(m_addr));
    checkVal({tag, ".w_data"}, W_Data, m_data);
    checkVal({tag, ".wr_cnt"}, 32'(Wr_Cnt), 32'(m_cnt));
  endtask

  // Advance one clock edge, apply the spec rules to the model, and return to posedge+1.
  task automatic stepClock();
    int g;
    g = expGrant();
    @(posedge Clk);
    if (Reset) begin
      modelReset();
    end else if (g >= 0) begin
      m_addr = (g == 0) ? Addr0 : Addr1;
      m_data = (g == 0) ? Data0 : Data1;
      m_last = g;
      m_wr   = (m_addr != 0);
      if (m_wr) m_cnt = (m_cnt + 1) % 65536;
    end else begin
      m_wr = 1'b0;
    end
    #1;
  endtask

  // Assert reset away from the clock edge, check its immediate effect, then release it after an edge.
  task automatic doReset(input string tag);
    Reset = 1'b1;
    modelReset();
    checkOutput(tag);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    int ack_seq[4];
    int addr_seq[4];
    ack_seq  = '{0, 1, 0, 1};
    addr_seq = '{1, 2, 1, 2};
    Reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    modelReset();
    #2;

    // Reset state, with a request pending that must not be consumed.
    Req0 = 1'b1; Addr0 = 5'd9;
    doReset("reset");

    // A single write is acknowledged, then issued on the following cycle.
    applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    checkOutput("single");
    checkVal("single.ack0_const", 32'(Ack0), 32'd1);
    stepClock();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("single_issue");
    checkVal("single.wr_const", 32'(Write_Reg), 32'd1);
    checkVal("single.addr_const", 32'(W_Addr), 32'd5);
    checkVal("single.data_const", W_Data, 32'hDEADBEEF);
    checkVal("single.cnt_const", 32'(Wr_Cnt), 32'd1);
    stepClock();

    // Continuous contention after reset alternates starting with requester 0.
    doReset("reset2");
    applyStimulus(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
    for (int i = 0; i < 4; i++) begin
      checkOutput("rr");
      checkVal("rr.ack0_seq", 32'(Ack0), 32'(ack_seq[i] == 0));
      checkVal("rr.ack1_seq", 32'(Ack1), 32'(ack_seq[i] == 1));
      stepClock();
      checkVal("rr.addr_seq", 32'(W_Addr), 32'(addr_seq[i]));
    end
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("rr_end");
    checkVal("rr.cnt_const", 32'(Wr_Cnt), 32'd4);
    stepClock();

    // A write to address 0 is acknowledged but never issued.
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234);
    checkOutput("zero");
    checkVal("zero.ack1_const", 32'(Ack1), 32'd1);
    stepClock();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("zero_issue");
    checkVal("zero.wr_const", 32'(Write_Reg), 32'd0);
    checkVal("zero.data_const", W_Data, 32'h1234);
    checkVal("zero.cnt_const", 32'(Wr_Cnt), 32'd4);
    stepClock();

    // Hold blocks contention; when Hold falls, the requester other than the last one wins.
    applyStimulus(1'b1, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    for (int i = 0; i < 3; i++) begin
      checkOutput("hold");
      stepClock();
    end
    Hold = 1'b0;
    checkOutput("hold_release");
    checkVal("hold.ack0_const", 32'(Ack0), 32'd1);
    stepClock();

    // Random traffic checked cycle by cycle against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 3) == 0), 1'($urandom), 5'($urandom_range(0, 7)),
                    $urandom, 1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      checkOutput("rand");
      stepClock();
    end

    // Write counter wrap: 65535 issued writes, then one more, brings the count back to 0.
    doReset("reset3");
    applyStimulus(1'b0, 1'b1, 5'd1, 32'hA5A5A5A5, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 65535; i++) stepClock();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("wrap_pre");
    checkVal("wrap.cnt_ffff", 32'(Wr_Cnt), 32'h0000FFFF);
    Req0 = 1'b1; Addr0 = 5'd7;
    stepClock();
    Req0 = 1'b0;
    checkOutput("wrap");
    checkVal("wrap.cnt_zero", 32'(Wr_Cnt), 32'd0);
    stepClock();

    // Reset during a write pulse clears everything at once; requester 0 then wins first.
    applyStimulus(1'b0, 1'b1, 5'd3, 32'hCAFEF00D, 1'b0, 5'd0, 32'd0);
    checkOutput("midrst_grant");
    stepClock();
    checkOutput("midrst_pulse");
    checkVal("midrst.pulse_const", 32'(Write_Reg), 32'd1);
    #2;
    Reset = 1'b1;
    modelReset();
    #1;
    checkVal("midrst.wr", 32'(Write_Reg), 32'd0);
    checkVal("midrst.addr", 32'(W_Addr), 32'd0);
    checkVal("midrst.data", W_Data, 32'd0);
    checkVal("midrst.cnt", 32'(Wr_Cnt), 32'd0);
    checkVal("midrst.ack0", 32'(Ack0), 32'd0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    Req1 = 1'b1; Addr1 = 5'd6; Data1 = 32'h66;
    checkOutput("midrst_after");
    checkVal("midrst.first_ack0", 32'(Ack0), 32'd1);
    stepClock();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("midrst_issue");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
